fcl_layer1_ctrl: RTL and testbench

FCL_LAYER1_CTRL -- requirements
Module: fcl_layer1_ctrl

---
 rtl/fcl_layer1_ctrl.sv | 121 ++++++++++++
 tb/tb_fcl_layer1_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fcl_layer1_ctrl.sv
// fcl_layer1_ctrl: per-filter LOAD -> CLR -> MAC -> NEXT sequencer for fully-connected layer 1.
// Define FCL_CTRL_TIMEOUT_EN to add a LOAD-wait timeout with a sticky ERR state.
module fcl_layer1_ctrl #(
   parameter int NUM_FILTER = 6,
   parameter int CNT_WIDTH  = 3,
   parameter int MAC_CYCLES = 5,
   parameter int MAC_CNTW   = 3,
   parameter int TIMEOUT    = 16
) (
   input  logic                 fcl_ctrl_clk,
   input  logic                 fcl_ctrl_rst_b,
   input  logic                 fcl_ctrl_start_i,
   input  logic                 fcl_ctrl_abort_i,
   output logic                 fcl_ctrl_wr_en_o,
   input  logic                 fcl_ctrl_wr_done_i,
   output logic                 fcl_ctrl_mac_clr_o,
   output logic                 fcl_ctrl_mac_en_o,
   output logic [CNT_WIDTH-1:0] fcl_ctrl_filt_idx_o,
   output logic                 fcl_ctrl_busy_o,
   output logic                 fcl_ctrl_done_o,
   output logic                 fcl_ctrl_err_o
);
`ifdef FCL_CTRL_TIMEOUT_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_MAC, S_NEXT, S_DONE, S_ERR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_MAC, S_NEXT, S_DONE} state_t;
`endif

   if (NUM_FILTER < 1 || NUM_FILTER > (1 << CNT_WIDTH) || MAC_CYCLES < 1 ||
       MAC_CYCLES > (1 << MAC_CNTW) || TIMEOUT < 1) begin : g_bad_param
      $error("fcl_layer1_ctrl: parameter out of range");
   end

   state_t               r_state, w_next;
   logic [CNT_WIDTH-1:0] r_idx, w_idx;
   logic [MAC_CNTW-1:0]  r_mcnt, w_mcnt;
   logic                 r_wr_en, r_clr, r_mac_en, r_busy, r_done;

`ifdef FCL_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_tcnt, w_tcnt;
   logic          r_err;

   // counts consecutive LOAD cycles; restarts on every LOAD entry
   assign w_tcnt = (r_state == S_LOAD && w_next == S_LOAD) ? r_tcnt + 1'b1 : '0;

   always_ff @(posedge fcl_ctrl_clk or negedge fcl_ctrl_rst_b)
      if (!fcl_ctrl_rst_b) begin
         r_tcnt <= '0;
         r_err  <= 1'b0;
      end else begin
         r_tcnt <= w_tcnt;
         r_err  <= w_next == S_ERR;
      end

   assign fcl_ctrl_err_o = r_err;
`else
   assign fcl_ctrl_err_o = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      w_idx  = r_idx;
      case (r_state)
         S_IDLE: w_next = fcl_ctrl_start_i ? S_LOAD : S_IDLE;
         S_LOAD: begin
            if (fcl_ctrl_wr_done_i) w_next = S_CLR;
`ifdef FCL_CTRL_TIMEOUT_EN
            else if (r_tcnt == TW'(TIMEOUT - 1)) w_next = S_ERR;
`endif
         end
         S_CLR:  w_next = S_MAC;
         S_MAC:  w_next = (r_mcnt == MAC_CNTW'(MAC_CYCLES - 1)) ? S_NEXT : S_MAC;
         S_NEXT: begin
            w_next = (r_idx == CNT_WIDTH'(NUM_FILTER - 1)) ? S_DONE : S_LOAD;
            w_idx  = (r_idx == CNT_WIDTH'(NUM_FILTER - 1)) ? '0 : r_idx + 1'b1;
         end
         S_DONE: w_next = S_IDLE;
`ifdef FCL_CTRL_TIMEOUT_EN
         S_ERR:  w_next = S_ERR;
`endif
         default: w_next = S_IDLE;
      endcase
      if (fcl_ctrl_abort_i) begin
         w_next = S_IDLE;
         w_idx  = '0;
      end
   end

   assign w_mcnt = (r_state == S_MAC && w_next == S_MAC) ? r_mcnt + 1'b1 : '0;

   // outputs are registered from the next state so they line up with r_state
   always_ff @(posedge fcl_ctrl_clk or negedge fcl_ctrl_rst_b)
      if (!fcl_ctrl_rst_b) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_mcnt   <= '0;
         r_wr_en  <= 1'b0;
         r_clr    <= 1'b0;
         r_mac_en <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_idx    <= w_idx;
         r_mcnt   <= w_mcnt;
         r_wr_en  <= w_next == S_LOAD;
         r_clr    <= w_next == S_CLR;
         r_mac_en <= w_next == S_MAC;
         r_busy   <= w_next inside {S_LOAD, S_CLR, S_MAC, S_NEXT};
         r_done   <= w_next == S_DONE;
      end

   assign fcl_ctrl_wr_en_o    = r_wr_en;
   assign fcl_ctrl_mac_clr_o  = r_clr;
   assign fcl_ctrl_mac_en_o   = r_mac_en;
   assign fcl_ctrl_filt_idx_o = r_idx;
   assign fcl_ctrl_busy_o     = r_busy;
   assign fcl_ctrl_done_o     = r_done;

endmodule

// File: tb/tb_fcl_layer1_ctrl.sv
// tb_fcl_layer1_ctrl: randomized scoreboard bench; expected outputs come from a per-run phase plan.
module tb_fcl_layer1_ctrl;
   localparam int NF = 6;
   localparam int CW = 3;
   localparam int MC = 5;
   localparam int TO = 16;
   localparam int K_IDLE = 0, K_LOAD = 1, K_CLR = 2, K_MAC = 3, K_NEXT = 4, K_DONE = 5, K_ERR = 6;

   typedef struct packed {
      logic          wr_en;
      logic          clr;
      logic          mac_en;
      logic          busy;
      logic          done;
      logic          err;
      logic [CW-1:0] idx;
   } out_t;

   logic          clk   = 1'b0;
   logic          rst_b = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          wd    = 1'b0;
   logic          wr_en, clr, mac_en, busy, done, err;
   logic [CW-1:0] idx;
   out_t          act;
   int errors = 0, checks = 0, cyc = 0;
   int n_done = 0, n_mac = 0, n_clr = 0, n_busy = 0, done_edge = -1;
   out_t exp_q[$];

   fcl_layer1_ctrl #(.NUM_FILTER(NF), .CNT_WIDTH(CW), .MAC_CYCLES(MC), .MAC_CNTW(3), .TIMEOUT(TO)) dut (
      .fcl_ctrl_clk(clk),
      .fcl_ctrl_rst_b(rst_b),
      .fcl_ctrl_start_i(start),
      .fcl_ctrl_abort_i(abort),
      .fcl_ctrl_wr_en_o(wr_en),
      .fcl_ctrl_wr_done_i(wd),
      .fcl_ctrl_mac_clr_o(clr),
      .fcl_ctrl_mac_en_o(mac_en),
      .fcl_ctrl_filt_idx_o(idx),
      .fcl_ctrl_busy_o(busy),
      .fcl_ctrl_done_o(done),
      .fcl_ctrl_err_o(err)
   );

   assign act = {wr_en, clr, mac_en, busy, done, err, idx};
   always #5 clk = ~clk;

   task automatic check(input string name, input out_t a, input out_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s @edge %0d: got %b required %b (wr_en clr mac_en busy done err idx)", name, cyc, a, e);
      end
   endtask

   task automatic check_int(input string name, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, a, e);
      end
   endtask

   // expected outputs while the block sits in phase k working on filter f
   function automatic out_t ph(input int k, input int f);
      out_t o;
      o.wr_en  = k == K_LOAD;
      o.clr    = k == K_CLR;
      o.mac_en = k == K_MAC;
      o.busy   = k >= K_LOAD && k <= K_NEXT;
      o.done   = k == K_DONE;
      o.err    = k == K_ERR;
      o.idx    = (k >= K_LOAD && k <= K_NEXT) ? CW'(f) : '0;
      return o;
   endfunction

   function automatic int off(input int l[NF], input int f);
      int s = 0;
      for (int g = 0; g < f; g++) s += l[g] + MC + 2;
      return s;
   endfunction

   // monitor: one expectation per rising edge, compared #1 later
   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mac_en) n_mac++;
      if (clr) n_clr++;
      if (busy) n_busy++;
      if (done) begin
         n_done++;
         done_edge = cyc;
      end
      if (exp_q.size() > 0) check("cycle", act, exp_q.pop_front());
   end

   always @(negedge rst_b) begin
      #1;
      check("async_reset", act, '0);
   end

   task automatic step(input logic s, input logic w, input logic a, input out_t e);
      @(negedge clk);
      start = s;
      wd    = w;
      abort = a;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input bit stray);
      for (int i = 0; i < n; i++)
         step(1'b0, stray ? 1'($urandom_range(0, 1)) : 1'b0,
              stray ? 1'($urandom_range(0, 1)) : 1'b0, ph(K_IDLE, 0));
   endtask

   task automatic run(input int l[NF], input int abort_at, input int rst_at, input bit noise,
                      output int start_edge);
      out_t plan[$];
      logic wdp[$];
      out_t cur;
      logic s, w;
      for (int f = 0; f < NF; f++) begin
         for (int j = 1; j <= l[f]; j++) begin
            plan.push_back(ph(K_LOAD, f));
            wdp.push_back(j == l[f]);
         end
         plan.push_back(ph(K_CLR, f));
         wdp.push_back(1'b0);
         for (int k = 0; k < MC; k++) begin
            plan.push_back(ph(K_MAC, f));
            wdp.push_back(1'b0);
         end
         plan.push_back(ph(K_NEXT, f));
         wdp.push_back(1'b0);
      end
      plan.push_back(ph(K_DONE, 0));
      wdp.push_back(1'b0);
      plan.push_back(ph(K_IDLE, 0));
      wdp.push_back(1'b0);
      step(1'b1, 1'b0, 1'b0, plan[0]);
      start_edge = cyc + 1;
      for (int i = 1; i < plan.size(); i++) begin
         cur = plan[i-1];
         w = cur.wr_en ? wdp[i-1] : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
         s = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (i == rst_at) begin
            @(posedge clk);
            #3 rst_b = 1'b0;
            for (int r = 0; r < 3; r++) step(1'b1, 1'b1, 1'b0, ph(K_IDLE, 0));
            @(negedge clk);
            rst_b = 1'b1;
            start = 1'b0;
            wd    = 1'b0;
            return;
         end
         if (i == abort_at) begin
            step(s, w, 1'b1, ph(K_IDLE, 0));
            return;
         end
         step(s, w, 1'b0, plan[i]);
      end
   endtask

   task automatic hold_load(input int n);
      step(1'b1, 1'b0, 1'b0, ph(K_LOAD, 0));
      for (int i = 1; i < n; i++)
`ifdef FCL_CTRL_TIMEOUT_EN
         step(1'($urandom_range(0, 1)), 1'b0, 1'b0, i < TO ? ph(K_LOAD, 0) : ph(K_ERR, 0));
`else
         step(1'($urandom_range(0, 1)), 1'b0, 1'b0, ph(K_LOAD, 0));
`endif
      step(1'b0, 1'b0, 1'b1, ph(K_IDLE, 0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int l[NF];
      int se, d0, m0, c0, b0;
      #1 rst_b = 1'b0;
      repeat (3) @(negedge clk);
      rst_b = 1'b1;
      idle(4, 1'b1);

      foreach (l[f]) l[f] = 3;
      d0 = n_done; b0 = n_busy;
      run(l, -1, -1, 1'b0, se);
      idle(2, 1'b0);
      check_int("done_cycle_L3", done_edge - se + 1, 61);
      check_int("busy_cycles_L3", n_busy - b0, 60);
      check_int("done_pulses_L3", n_done - d0, 1);

      foreach (l[f]) l[f] = 1 + int'($urandom_range(0, 3));
      d0 = n_done;
      run(l, off(l, 2) + l[2] + 2 + int'($urandom_range(0, MC - 1)), -1, 1'b1, se);
      idle(3, 1'b1);
      check_int("done_pulses_abort", n_done - d0, 0);

      foreach (l[f]) l[f] = 1 + int'($urandom_range(0, 3));
      d0 = n_done;
      run(l, -1, -1, 1'b1, se);
      idle(2, 1'b1);
      check_int("done_pulses_rand", n_done - d0, 1);

      foreach (l[f]) l[f] = 1 + int'($urandom_range(0, 3));
      d0 = n_done;
      run(l, -1, off(l, 4) + 1, 1'b1, se);
      idle(3, 1'b1);
      check_int("done_pulses_reset", n_done - d0, 0);

      foreach (l[f]) l[f] = 1;
      d0 = n_done; m0 = n_mac; c0 = n_clr;
      run(l, -1, -1, 1'b0, se);
      idle(2, 1'b0);
      check_int("done_cycle_L1", done_edge - se + 1, 49);
      check_int("mac_en_cycles_L1", n_mac - m0, NF * MC);
      check_int("mac_clr_pulses_L1", n_clr - c0, NF);
      check_int("done_pulses_L1", n_done - d0, 1);

      hold_load(40);
      idle(3, 1'b1);

      repeat (2) @(negedge clk);
      check_int("queue_drain", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
